vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vram_addr_gen.sv | 30 +++
 rtl/vram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared definitions for the VGA frame-buffer arbiter:
//                default geometry/pixel/address widths and the arbiter FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int VGA_H_DATA = 640;   // visible pixels per line
    localparam int VGA_V_DATA = 480;   // visible lines per frame
    localparam int VGA_PIX_W  = 12;    // 4:4:4 RGB
    localparam int VGA_ADDR_W = 19;    // covers VGA_H_DATA * VGA_V_DATA

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } vga_state_e;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vram_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vram_addr_gen
//  Description : Converts a pixel coordinate into a linear frame-buffer
//                address (y*H_DATA + x, truncated to ADDR_W) and flags
//                whether the coordinate lies inside the visible area.
//  Ports       : x_i, y_i     - 11-bit pixel coordinate
//                addr_o       - linear RAM address
//                in_range_o   - 1 when x_i < H_DATA and y_i < V_DATA
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_addr_gen #(
    parameter int H_DATA = 640,
    parameter int V_DATA = 480,
    parameter int ADDR_W = 19
) (
    input  logic [10:0]       x_i,
    input  logic [10:0]       y_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              in_range_o
);

    localparam logic [31:0] H_LIM = H_DATA;
    localparam logic [31:0] V_LIM = V_DATA;

    assign addr_o     = ADDR_W'((32'(y_i) * H_LIM) + 32'(x_i));
    assign in_range_o = (32'(x_i) < H_LIM) && (32'(y_i) < V_LIM);

endmodule : vram_addr_gen
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vram_arbiter
//  Description : Single-port frame-buffer arbiter. Display reads have
//                absolute priority; draw writes are accepted when the
//                arbiter is idle and the display is not reading; a clear
//                engine fills the whole frame with one colour, stalling
//                whenever the display reads. All RAM controls are registered.
//  Ports       : px_clk, rst_n                 - clock, async active-low reset
//                disp_req_i/disp_h_i/disp_v_i  - display fetch request
//                disp_data_o                   - fetched pixel (latency 3)
//                wr_valid_i/wr_ready_o/wr_x_i/wr_y_i/wr_data_i - draw port
//                oob_drop_o                    - discarded out-of-range write
//                clr_start_i/clr_color_i/clr_busy_o/clr_done_o - clear engine
//                mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i - RAM
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int H_DATA = VGA_H_DATA,
    parameter int V_DATA = VGA_V_DATA,
    parameter int PIX_W  = VGA_PIX_W,
    parameter int ADDR_W = VGA_ADDR_W
) (
    input  logic              px_clk,
    input  logic              rst_n,
    input  logic              disp_req_i,
    input  logic [10:0]       disp_h_i,
    input  logic [10:0]       disp_v_i,
    output logic [PIX_W-1:0]  disp_data_o,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [10:0]       wr_x_i,
    input  logic [10:0]       wr_y_i,
    input  logic [PIX_W-1:0]  wr_data_i,
    output logic              oob_drop_o,
    input  logic              clr_start_i,
    input  logic [PIX_W-1:0]  clr_color_i,
    output logic              clr_busy_o,
    output logic              clr_done_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [PIX_W-1:0]  mem_wdata_o,
    input  logic [PIX_W-1:0]  mem_rdata_i
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_DATA * V_DATA - 1);

    vga_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [PIX_W-1:0]  clr_color_q, clr_color_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic              oob_q, oob_d;
    logic              done_q, done_d;

    // Display return pipeline: stage 1 aligns with the RAM access cycle,
    // stage 2 with the cycle the RAM presents its read data.
    logic              rd_v1_q, rd_ok1_q, rd_v2_q, rd_ok2_q;
    logic [PIX_W-1:0]  disp_data_q;

    logic [ADDR_W-1:0] disp_addr, wr_addr;
    logic              disp_in_range, wr_in_range;
    logic              wr_accept;

    vram_addr_gen #(.H_DATA(H_DATA), .V_DATA(V_DATA), .ADDR_W(ADDR_W)) u_disp_addr (
        .x_i        (disp_h_i),
        .y_i        (disp_v_i),
        .addr_o     (disp_addr),
        .in_range_o (disp_in_range)
    );

    vram_addr_gen #(.H_DATA(H_DATA), .V_DATA(V_DATA), .ADDR_W(ADDR_W)) u_draw_addr (
        .x_i        (wr_x_i),
        .y_i        (wr_y_i),
        .addr_o     (wr_addr),
        .in_range_o (wr_in_range)
    );

    assign wr_ready_o = (state_q == ST_IDLE) && !disp_req_i && !clr_start_i;
    assign wr_accept  = wr_valid_i && wr_ready_o;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        clr_color_d = clr_color_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        oob_d       = 1'b0;
        done_d      = 1'b0;

        // A clear may be armed even while the display is reading; arming
        // itself touches no RAM.
        if ((state_q == ST_IDLE) && clr_start_i) begin
            state_d     = ST_CLEAR;
            clr_cnt_d   = '0;
            clr_color_d = clr_color_i;
        end

        if (disp_req_i) begin
            if (disp_in_range) begin
                mem_en_d   = 1'b1;
                mem_addr_d = disp_addr;
            end
        end else if (wr_accept) begin
            if (wr_in_range) begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = wr_addr;
                mem_wdata_d = wr_data_i;
            end else begin
                oob_d = 1'b1;
            end
        end else if (state_q == ST_CLEAR) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = clr_cnt_q;
            mem_wdata_d = clr_color_q;
            if (clr_cnt_q == LAST_ADDR) begin
                // Registered, so the pulse coincides with the final write.
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                clr_cnt_d = clr_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            clr_cnt_q   <= '0;
            clr_color_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            oob_q       <= 1'b0;
            done_q      <= 1'b0;
            rd_v1_q     <= 1'b0;
            rd_ok1_q    <= 1'b0;
            rd_v2_q     <= 1'b0;
            rd_ok2_q    <= 1'b0;
            disp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_color_q <= clr_color_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            oob_q       <= oob_d;
            done_q      <= done_d;
            rd_v1_q     <= disp_req_i;
            rd_ok1_q    <= disp_req_i && disp_in_range;
            rd_v2_q     <= rd_v1_q;
            rd_ok2_q    <= rd_ok1_q;
            // Out-of-range fetches never reached RAM and return black.
            if (rd_v2_q) begin
                disp_data_q <= rd_ok2_q ? mem_rdata_i : '0;
            end
        end
    end

    assign disp_data_o = disp_data_q;
    assign oob_drop_o  = oob_q;
    assign clr_busy_o  = (state_q == ST_CLEAR);
    assign clr_done_o  = done_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule : vram_arbiter
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_arbiter
//  Description : Self-checking bench for vram_arbiter on a reduced 40x30
//                frame so that full clears fit in a short run. Coordinates
//                (39,29) and (0,30)/(40,0) play the role of the last pixel
//                and the out-of-range edges of the full-size frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    localparam int H    = 40;
    localparam int V    = 30;
    localparam int PW   = 12;
    localparam int AW   = 11;
    localparam int NPIX = H * V;

    logic          px_clk = 1'b0;
    logic          rst_n;
    logic          disp_req;
    logic [10:0]   disp_h, disp_v;
    logic [PW-1:0] disp_data;
    logic          wr_valid, wr_ready;
    logic [10:0]   wr_x, wr_y;
    logic [PW-1:0] wr_data;
    logic          oob_drop;
    logic          clr_start;
    logic [PW-1:0] clr_color;
    logic          clr_busy, clr_done;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_wdata, mem_rdata;

    vram_arbiter #(.H_DATA(H), .V_DATA(V), .PIX_W(PW), .ADDR_W(AW)) dut (
        .px_clk      (px_clk),
        .rst_n       (rst_n),
        .disp_req_i  (disp_req),
        .disp_h_i    (disp_h),
        .disp_v_i    (disp_v),
        .disp_data_o (disp_data),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .wr_x_i      (wr_x),
        .wr_y_i      (wr_y),
        .wr_data_i   (wr_data),
        .oob_drop_o  (oob_drop),
        .clr_start_i (clr_start),
        .clr_color_i (clr_color),
        .clr_busy_o  (clr_busy),
        .clr_done_o  (clr_done),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    always #5 px_clk = ~px_clk;

    // Synchronous single-port RAM, read data one cycle after mem_en.
    logic [PW-1:0] ram [0:2047];
    always @(posedge px_clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    typedef struct { int due; logic [PW-1:0] val; } pend_t;
    pend_t         pq[$];
    bit            m_clearing;
    int            m_idx;
    logic [PW-1:0] m_col;
    logic [PW-1:0] shadow [0:2047];
    logic          e_en, e_we, e_oob, e_done;
    int            e_addr;
    logic [PW-1:0] e_wdata, e_disp;
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_clearing = 1'b0; m_idx = 0; m_col = '0;
        e_en = 1'b0; e_we = 1'b0; e_oob = 1'b0; e_done = 1'b0;
        e_addr = 0; e_wdata = '0; e_disp = '0;
        pq.delete();
    endtask

    task automatic set_idle();
        disp_req = 1'b0; disp_h = '0; disp_v = '0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        clr_start = 1'b0; clr_color = '0;
    endtask

    task automatic check_cycle();
        pend_t p;
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            p = pq.pop_front();
            e_disp = p.val;
        end
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_en)  chk("mem_addr", 32'(mem_addr), e_addr);
        if (e_we)  chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        chk("oob_drop", 32'(oob_drop), 32'(e_oob));
        chk("clr_done", 32'(clr_done), 32'(e_done));
        chk("clr_busy", 32'(clr_busy), 32'(m_clearing));
        chk("wr_ready", 32'(wr_ready), 32'(!m_clearing && !disp_req && !clr_start));
        chk("disp_data", 32'(disp_data), 32'(e_disp));
    endtask

    // Applies this cycle's inputs to the rules and predicts next cycle's bus.
    task automatic model_step();
        bit was_clearing = m_clearing;
        bit ready = !m_clearing && !disp_req && !clr_start;
        int a;
        pend_t p;
        e_en = 1'b0; e_we = 1'b0; e_oob = 1'b0; e_done = 1'b0;
        if (disp_req) begin
            p.due = cyc + 3;
            if (int'(disp_h) < H && int'(disp_v) < V) begin
                a = int'(disp_v) * H + int'(disp_h);
                e_en = 1'b1; e_addr = a;
                p.val = shadow[a];
            end else begin
                p.val = '0;
            end
            pq.push_back(p);
        end else if (wr_valid && ready) begin
            if (int'(wr_x) < H && int'(wr_y) < V) begin
                a = int'(wr_y) * H + int'(wr_x);
                e_en = 1'b1; e_we = 1'b1; e_addr = a; e_wdata = wr_data;
                shadow[a] = wr_data;
            end else begin
                e_oob = 1'b1;
            end
        end else if (was_clearing) begin
            e_en = 1'b1; e_we = 1'b1; e_addr = m_idx; e_wdata = m_col;
            shadow[m_idx] = m_col;
            if (m_idx == NPIX - 1) begin
                e_done = 1'b1; m_clearing = 1'b0;
            end else begin
                m_idx++;
            end
        end
        if (!was_clearing && clr_start) begin
            m_clearing = 1'b1; m_idx = 0; m_col = clr_color;
        end
    endtask

    task automatic tick();
        @(negedge px_clk);
        check_cycle();
        model_step();
        @(posedge px_clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic [10:0]   x, y;
        logic [PW-1:0] d;
        int            exp_addr;
        logic          exp_oob;
    } wvec_t;
    wvec_t tbl [8];

    initial begin
        int nw, nd, bad;

        tbl[0] = '{11'd10,   11'd2,    12'hF00, 90,   1'b0};
        tbl[1] = '{11'd0,    11'd0,    12'h123, 0,    1'b0};
        tbl[2] = '{11'd39,   11'd29,   12'hABC, 1199, 1'b0};
        tbl[3] = '{11'd39,   11'd0,    12'h055, 39,   1'b0};
        tbl[4] = '{11'd0,    11'd29,   12'h0AA, 1160, 1'b0};
        tbl[5] = '{11'd40,   11'd0,    12'h0F0, 0,    1'b1};
        tbl[6] = '{11'd0,    11'd30,   12'h111, 0,    1'b1};
        tbl[7] = '{11'd2047, 11'd2047, 12'h222, 0,    1'b1};

        // ---- reset state ----
        rst_n = 1'b0;
        set_idle();
        model_reset();
        repeat (3) @(posedge px_clk);
        #1;
        chk("rst_disp_data", 32'(disp_data), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_oob", 32'(oob_drop), 0);
        chk("rst_done", 32'(clr_done), 0);
        chk("rst_busy", 32'(clr_busy), 0);
        @(negedge px_clk);
        rst_n = 1'b1;
        @(posedge px_clk);
        #1;

        // ---- table-driven draw writes ----
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_x = tbl[i].x; wr_y = tbl[i].y; wr_data = tbl[i].d;
            tick();
            set_idle();
            chk("tbl_en", 32'(mem_en), 32'(!tbl[i].exp_oob));
            chk("tbl_oob", 32'(oob_drop), 32'(tbl[i].exp_oob));
            if (!tbl[i].exp_oob) begin
                chk("tbl_addr", 32'(mem_addr), tbl[i].exp_addr);
                chk("tbl_wdata", 32'(mem_wdata), 32'(tbl[i].d));
            end
            tick();
        end

        // ---- back-to-back display reads of first and last pixel ----
        disp_req = 1'b1; disp_h = 11'd0; disp_v = 11'd0;
        tick();
        disp_h = 11'd39; disp_v = 11'd29;
        chk("rd0_en", 32'(mem_en), 1);
        chk("rd0_we", 32'(mem_we), 0);
        chk("rd0_addr", 32'(mem_addr), 0);
        tick();
        set_idle();
        chk("rd1_addr", 32'(mem_addr), 1199);
        tick();
        chk("rd0_data", 32'(disp_data), 32'h123);
        tick();
        chk("rd1_data", 32'(disp_data), 32'hABC);
        tick();

        // ---- write held off by display, accepted once display idles ----
        wr_valid = 1'b1; wr_x = 11'd10; wr_y = 11'd2; wr_data = 12'h5A5;
        disp_req = 1'b1; disp_h = 11'd5; disp_v = 11'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("blk_we", 32'(mem_we), 0);
        end
        disp_req = 1'b0;
        #1;
        chk("blk_ready", 32'(wr_ready), 1);
        tick();
        set_idle();
        chk("blk_we_go", 32'(mem_we), 1);
        chk("blk_addr", 32'(mem_addr), 90);
        chk("blk_wdata", 32'(mem_wdata), 32'h5A5);
        tick();

        // ---- out-of-range write and display fetch ----
        wr_valid = 1'b1; wr_x = 11'd40; wr_y = 11'd0; wr_data = 12'h0F0;
        tick();
        set_idle();
        chk("oobw_pulse", 32'(oob_drop), 1);
        chk("oobw_en", 32'(mem_en), 0);
        tick();
        chk("oobw_pulse_end", 32'(oob_drop), 0);
        disp_req = 1'b1; disp_h = 11'd0; disp_v = 11'd30;
        tick();
        set_idle();
        chk("oobr_en", 32'(mem_en), 0);
        tick();
        tick();
        chk("oobr_data", 32'(disp_data), 0);
        tick();

        // ---- full clear with display toggling; same-cycle write refused ----
        clr_start = 1'b1; clr_color = 12'h00F;
        wr_valid = 1'b1; wr_x = 11'd1; wr_y = 11'd1; wr_data = 12'h777;
        tick();
        set_idle();
        nw = 0; nd = 0;
        for (int i = 0; i < 4 * NPIX && nd == 0; i++) begin
            disp_req = cyc[0];
            disp_h = 11'($urandom_range(0, H - 1));
            disp_v = 11'($urandom_range(0, V - 1));
            wr_valid = 1'($urandom);
            tick();
            if (mem_we)   nw++;
            if (clr_done) nd++;
        end
        set_idle();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (clr_done) nd++;
        end
        chk("clr_writes", 32'(nw), NPIX);
        chk("clr_done_once", 32'(nd), 1);
        bad = 0;
        for (int i = 0; i < NPIX; i++) if (ram[i] !== 12'h00F) bad++;
        chk("clr_ram_fill", 32'(bad), 0);

        // ---- reset in the middle of a clear ----
        clr_start = 1'b1; clr_color = 12'h3C3;
        tick();
        set_idle();
        nw = 0;
        for (int i = 0; i < 4 * NPIX && nw < 1000; i++) begin
            disp_req = cyc[0];
            disp_h = 11'($urandom_range(0, H - 1));
            disp_v = 11'($urandom_range(0, V - 1));
            tick();
            if (mem_we) nw++;
        end
        chk("mid_reached", 32'(nw), 1000);
        set_idle();
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(clr_busy), 0);
        chk("mid_en", 32'(mem_en), 0);
        chk("mid_done", 32'(clr_done), 0);
        chk("mid_disp", 32'(disp_data), 0);
        model_reset();
        repeat (2) @(posedge px_clk);
        @(negedge px_clk);
        rst_n = 1'b1;
        @(posedge px_clk);
        #1;
        cyc++;
        for (int i = 0; i < 5; i++) tick();

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 3000; i++) begin
            disp_req  = ($urandom_range(0, 2) == 0);
            disp_h    = ($urandom_range(0, 15) == 0) ? 11'h7FF : 11'($urandom_range(0, H + 3));
            disp_v    = 11'($urandom_range(0, V + 3));
            wr_valid  = 1'($urandom);
            wr_x      = 11'($urandom_range(0, H + 3));
            wr_y      = ($urandom_range(0, 15) == 0) ? 11'h7FF : 11'($urandom_range(0, V + 3));
            wr_data   = PW'($urandom);
            clr_start = ($urandom_range(0, 699) == 0);
            clr_color = PW'($urandom);
            tick();
        end
        set_idle();
        for (int i = 0; i < 5; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vram_arbiter
`default_nettype wire
